// File: rtl/aes_inv_key_schedule_pkg.sv
// aes_pkg: shared AES-128 constants, S-box/Rcon tables, scheduler state enum and word helpers
// No ports; imported by aes_sbox and aes_inv_key_schedule.
package aes_pkg;
    localparam int NR = 10;
    localparam int NK = 4;
    typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    // Entries 1..10 are the round constants; the rest pad the 4-bit index so no lookup goes out of range.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction
endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// aes_inv_key_schedule_if: load request and round-key stream between key loader, scheduler and round engine
// start/key_in: load request and key; rk_valid/rk_ready/rk_data/rk_round/rk_last: key stream; busy: scheduler active.
// slave is the scheduler side, master the loader/consumer side.
interface aes_inv_key_schedule_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
    modport master (output start, key_in, rk_ready, input rk_valid, rk_data, rk_round, rk_last, busy);
    modport slave (input start, key_in, rk_ready, output rk_valid, rk_data, rk_round, rk_last, busy);
endinterface

// File: rtl/aes_inv_key_schedule_sbox.sv
// aes_sbox: combinational 8-bit AES S-box lookup
// a: input byte; y: substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = SBOX[a];
endmodule

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: AES-128 round-key generator emitting keys 10 down to 0 by running the schedule backwards
// clk/rst: clock, async active-high reset; bus (slave): start/key_in load, rk_* round-key stream, busy.
// AES_FWD_PRECOMPUTE_EN: key_in is the cipher key and ten forward rounds run first on the same S-boxes.
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input logic clk,
    input logic rst,
    aes_inv_key_schedule_if.slave bus
);
    state_t state, state_n;
    logic [127:0] key, key_n;
    logic [3:0] round, round_n;
    logic [31:0] w0, w1, w2, w3, p1, p2, p3, sin, rw, sw, t0;
    assign {w0, w1, w2, w3} = key;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
`ifdef AES_FWD_PRECOMPUTE_EN
    logic [31:0] n1, n2, n3;
    assign sin = state == FWD ? w3 : p3;
    assign n1 = w1 ^ t0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
`else
    assign sin = p3;
`endif
    assign rw = rot_word(sin);
    genvar i;
    for (i = 0; i < 4; i++) begin : g_sb
        aes_sbox u_sbox (.a(rw[8*i+:8]), .y(sw[8*i+:8]));
    end
    // Word 0 of both the previous (inverse) and next (forward) key; round selects the Rcon in either direction.
    assign t0 = w0 ^ sw ^ {RCON[round], 24'h0};
    always_comb begin
        state_n = state;
        key_n = key;
        round_n = round;
        case (state)
            IDLE: if (bus.start) begin
                key_n = bus.key_in;
`ifdef AES_FWD_PRECOMPUTE_EN
                state_n = FWD;
                round_n = 4'd1;
`else
                state_n = EMIT;
                round_n = 4'(NR);
`endif
            end
`ifdef AES_FWD_PRECOMPUTE_EN
            FWD: begin
                key_n = {t0, n1, n2, n3};
                round_n = round == 4'(NR) ? round : round + 4'd1;
                state_n = round == 4'(NR) ? EMIT : FWD;
            end
`endif
            EMIT: if (bus.rk_ready) begin
                if (round == 4'd0) state_n = IDLE;
                else begin
                    key_n = {t0, p1, p2, p3};
                    round_n = round - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            key <= '0;
            round <= '0;
        end else begin
            state <= state_n;
            key <= key_n;
            round <= round_n;
        end
    end
    assign bus.rk_valid = state == EMIT;
    assign bus.rk_data = bus.rk_valid ? key : '0;
    assign bus.rk_round = bus.rk_valid ? round : '0;
    assign bus.rk_last = bus.rk_valid && round == 4'd0;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: table-driven scoreboard bench for the inverse key scheduler
module tb_aes_inv_key_schedule;
    logic clk, rst;
    aes_inv_key_schedule_if ifc();
    aes_inv_key_schedule dut (.clk(clk), .rst(rst), .bus(ifc));
    initial clk = 0;
    always #5 clk = ~clk;
`ifdef AES_FWD_PRECOMPUTE_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        logic [3:0]   round;
        logic [127:0] data;
        logic         last;
        bit           chk;
    } exp_t;
    typedef struct {
        logic [127:0]        key;
        logic [10:0][127:0]  exp;
        bit [10:0]           mask;
        int                  duty;
    } vec_t;
    exp_t sbq[$];
    vec_t vecs [3];
    logic [10:0][127:0] fips;
    int errors = 0, checks = 0;
    bit stalled;
    logic [132:0] held;
    task automatic check(input string n, input logic [135:0] a, input logic [135:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask
    task automatic sample();
        exp_t e;
        if (ifc.rk_valid && stalled) check("hold", 136'({ifc.rk_round, ifc.rk_last, ifc.rk_data}), 136'(held));
        stalled = ifc.rk_valid && !ifc.rk_ready;
        held = {ifc.rk_round, ifc.rk_last, ifc.rk_data};
        if (ifc.rk_valid && ifc.rk_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_key: got round %0d with nothing expected", ifc.rk_round);
            end else begin
                e = sbq.pop_front();
                check("round", 136'(ifc.rk_round), 136'(e.round));
                check("last", 136'(ifc.rk_last), 136'(e.last));
                if (e.chk) check("data", 136'(ifc.rk_data), 136'(e.data));
            end
        end
    endtask
    task automatic load(input int v);
        int lat;
        @(posedge clk);
        #1;
        ifc.start = 1;
        ifc.key_in = vecs[v].key;
        ifc.rk_ready = 0;
        for (int r = 10; r >= 0; r--)
            sbq.push_back('{round: 4'(r), data: vecs[v].exp[r], last: r == 0, chk: vecs[v].mask[r]});
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            ifc.start = 0;
            lat++;
            @(negedge clk);
            if (lat == 1) check("busy_rise", 136'(ifc.busy), 136'(1));
        end while (!ifc.rk_valid && lat < 40);
        check("latency", 136'(lat), 136'(LAT));
    endtask
    task automatic drain(input int duty, input bit poke, input int stop_left, output int cycles);
        stalled = 0;
        for (cycles = 0; cycles < 3000; ) begin
            @(posedge clk);
            #1;
            ifc.rk_ready = duty >= 100 ? 1'b1 : ($urandom_range(99) < duty);
            ifc.start = poke && (cycles == 3 || sbq.size() == 1);
            if (poke) ifc.key_in = ~vecs[0].key;
            @(negedge clk);
            sample();
            cycles++;
            if (sbq.size() <= stop_left) break;
        end
        check("drain_timeout", 136'(cycles >= 3000), 136'(0));
        if (stop_left == 0) begin
            @(posedge clk);
            #1;
            ifc.rk_ready = 0;
            ifc.start = 0;
            @(negedge clk);
            check("end_valid", 136'(ifc.rk_valid), 136'(0));
            check("end_busy", 136'(ifc.busy), 136'(0));
        end
    endtask
    initial begin
        int c;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_FWD_PRECOMPUTE_EN
        vecs[0] = '{key: fips[0], exp: fips, mask: '1, duty: 100};
        vecs[2] = '{key: '0, exp: '0, mask: 11'b11000000001, duty: 100};
        vecs[2].exp[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        vecs[2].exp[9] = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
`else
        vecs[0] = '{key: fips[10], exp: fips, mask: '1, duty: 100};
        vecs[2] = '{key: '0, exp: '0, mask: 11'b11100000000, duty: 100};
        vecs[2].exp[9] = 128'h55636363000000000000000000000000;
        vecs[2].exp[8] = 128'h2d000000556363630000000000000000;
`endif
        vecs[1] = vecs[0];
        vecs[1].duty = 30;
        rst = 1;
        ifc.start = 0;
        ifc.key_in = '0;
        ifc.rk_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", 136'({ifc.rk_valid, ifc.rk_data, ifc.rk_round, ifc.rk_last, ifc.busy}), 136'(0));
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            ifc.rk_ready = 1;
            @(negedge clk);
            check("idle_ready", 136'({ifc.rk_valid, ifc.busy}), 136'(0));
        end
        for (int v = 0; v < 3; v++) begin
            load(v);
            drain(vecs[v].duty, 0, 0, c);
            if (vecs[v].duty >= 100) check("throughput", 136'(c), 136'(11));
            check("sb_empty", 136'(sbq.size()), 136'(0));
        end
        load(0);
        drain(100, 1, 0, c);
        check("sb_empty_poke", 136'(sbq.size()), 136'(0));
        repeat (3) @(negedge clk);
        check("no_restart", 136'({ifc.rk_valid, ifc.busy}), 136'(0));
        load(0);
        drain(100, 0, 6, c);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("abort_out", 136'({ifc.rk_valid, ifc.rk_data, ifc.rk_round, ifc.rk_last, ifc.busy}), 136'(0));
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 0;
        repeat (2) @(negedge clk);
        check("abort_idle", 136'(ifc.busy), 136'(0));
        load(0);
        drain(100, 0, 0, c);
        check("sb_empty_rst", 136'(sbq.size()), 136'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
